// File: rtl/reg_cmd_sequencer_pkg.sv
// rtl/reg_cmd_sequencer_pkg.sv - shared mode constants, FSM states and command type
package reg_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    APPLY = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] mode;
  } cmd_t;

  // Output of the downstream mode-select register for a given Q and mode.
  function automatic logic [3:0] reg_y(input logic [3:0] q, input logic [1:0] mode);
    case (mode)
      MODE_INV: reg_y = ~q;
      MODE_SHR: reg_y = {1'b0, q[3:1]};
      MODE_SHL: reg_y = {q[2:0], 1'b0};
      default:  reg_y = q;
    endcase
  endfunction

endpackage

// File: rtl/reg_cmd_sequencer_if.sv
// rtl/reg_cmd_sequencer_if.sv - command valid/ready handshake bundle
interface reg_cmd_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [1:0] cmd_mode;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_mode,
    output cmd_ready
  );

endinterface

// File: rtl/reg_cmd_sequencer_fifo.sv
// rtl/reg_cmd_sequencer_fifo.sv - synchronous command FIFO with flush
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  // Full refuses a push even when a pop happens on the same edge; flush discards both.
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue by catching the read pointer up.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/reg_cmd_sequencer.sv
// rtl/reg_cmd_sequencer.sv - load-then-dwell command sequencer for the mode-select register
module reg_cmd_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DWELL      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                flush,
  reg_cmd_sequencer_if.slave  cmd_if,
  output logic [3:0]          D,
  output logic [1:0]          S,
  output logic                busy,
  output logic                done
);

  localparam int             CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DWELL - 1);

  seq_state_e    r_state, w_state_nxt;
  logic [3:0]    r_d, w_d_nxt;
  logic [1:0]    r_s, w_s_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_pop;
  logic          w_done;
  logic          w_full;
  logic          w_empty;
  logic [5:0]    w_rd_data;
  cmd_t          w_head;
  cmd_t          w_push_cmd;

  assign w_push_cmd = '{data: cmd_if.cmd_data, mode: cmd_if.cmd_mode};
  assign w_head     = cmd_t'(w_rd_data);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (6)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_flush (flush),
    .i_push  (cmd_if.cmd_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state and next-output decode; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_s_nxt     = r_s;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
      w_s_nxt     = MODE_HOLD;
    end else begin
      case (r_state)
        IDLE: begin
          w_s_nxt = MODE_HOLD;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_d_nxt     = w_head.data;
            w_mode_nxt  = w_head.mode;
            w_state_nxt = LOAD;
          end
        end
        LOAD: begin
          w_s_nxt     = r_mode;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = APPLY;
        end
        APPLY: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_done  = 1'b1;
            w_s_nxt = MODE_HOLD;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_d_nxt     = w_head.data;
              w_mode_nxt  = w_head.mode;
              w_state_nxt = LOAD;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_s_nxt     = MODE_HOLD;
        end
      endcase
    end
  end

  // State, dwell counter and registered D/S outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_s     <= MODE_HOLD;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_s     <= w_s_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign D                = r_d;
  assign S                = r_s;
  assign done             = w_done;
  assign busy             = (r_state != IDLE) || !w_empty;
  assign cmd_if.cmd_ready = !w_full;

endmodule
